// File: rtl/hatch_pkg.sv
// Shared definitions for the egg-hatch sequencer and dot-matrix display.
// Holds the state encoding, frame-index width and default frame numbers.
package hatch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_COLD,
        S_DONE,
        S_FAIL
    } state_t;

    localparam int NUM_W            = 4;
    localparam int HATCH_LAST_FRAME = 10;
    localparam int HATCH_FAIL_FRAME = 11;

endpackage

// File: rtl/hatch_timer.sv
// Up-counter with enable, synchronous clear and terminal-count flag.
// Ports: clk, rst (async high), en (count), clr (sync clear, wins over en),
//        tc (high while the count sits at TICKS-1).
module hatch_timer #(
    parameter int TICKS = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(TICKS - 1));

    // Rolls back to zero on the terminal count, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hatch_seq_ctrl.sv
// Incubation sequencer: steps the display frame every stage period, freezes
// while cold and fails after a long cold spell.
// Ports: clk, rst (async high), st (enable, low = clear), start (pulse),
//        temp_ok (1 = warm) -> num (frame), temp (red overlay),
//        busy (RUN/COLD), done (DONE), fail (FAIL). All outputs registered.
module hatch_seq_ctrl
    import hatch_pkg::*;
#(
    parameter int STAGE_TICKS = 2000,
    parameter int LAST_FRAME  = HATCH_LAST_FRAME,
    parameter int FAIL_FRAME  = HATCH_FAIL_FRAME,
    parameter int COLD_LIMIT  = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic             start,
    input  logic             temp_ok,
    output logic [NUM_W-1:0] num,
    output logic             temp,
    output logic             busy,
    output logic             done,
    output logic             fail
);

    state_t           state;
    state_t           state_n;
    logic [NUM_W-1:0] num_n;
    logic             active;
    logic             stage_tc;
    logic             cold_tc;

    assign active = (state == S_RUN) || (state == S_COLD);

    // A warm cycle in COLD already counts toward the stage, so a cold spell
    // delays the sequence by exactly its length.
    hatch_timer #(.TICKS(STAGE_TICKS)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (active && temp_ok),
        .clr (!st || !active),
        .tc  (stage_tc)
    );

    // The cycle that leaves RUN for COLD is the first cold cycle counted.
    hatch_timer #(.TICKS(COLD_LIMIT)) u_cold (
        .clk (clk),
        .rst (rst),
        .en  (active && !temp_ok),
        .clr (!st || !active || temp_ok),
        .tc  (cold_tc)
    );

    always_comb begin
        state_n = state;
        num_n   = num;
        if (!st) begin
            state_n = S_IDLE;
            num_n   = '0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE),
                (state == S_DONE),
                (state == S_FAIL): begin
                    if (start) begin
                        state_n = S_RUN;
                        num_n   = '0;
                    end
                end
                (state == S_RUN),
                (state == S_COLD): begin
                    if (!temp_ok) begin
                        if ((state == S_COLD) && cold_tc) begin
                            state_n = S_FAIL;
                            num_n   = NUM_W'(FAIL_FRAME);
                        end else begin
                            state_n = S_COLD;
                        end
                    end else begin
                        state_n = S_RUN;
                        if (stage_tc) begin
                            num_n = num + 1'b1;
                            if (num_n == NUM_W'(LAST_FRAME)) begin
                                state_n = S_DONE;
                            end
                        end
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    num_n   = '0;
                end
            endcase
        end
    end

    // Flags are decoded from the next state so they align with num.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            num   <= '0;
            temp  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            fail  <= 1'b0;
        end else begin
            state <= state_n;
            num   <= num_n;
            temp  <= (state_n == S_COLD) || (state_n == S_FAIL);
            busy  <= (state_n == S_RUN) || (state_n == S_COLD);
            done  <= (state_n == S_DONE);
            fail  <= (state_n == S_FAIL);
        end
    end

endmodule

// File: tb/tb_hatch_seq_ctrl.sv
// Self-checking bench for hatch_seq_ctrl: reference model feeding a
// scoreboard queue, a vector table for the cold/fail/st cases, and sequences.
module tb_hatch_seq_ctrl;

    localparam int ST = 4;
    localparam int CL = 6;
    localparam int LF = 10;
    localparam int FF = 11;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_COLD = 2;
    localparam int M_DONE = 3;
    localparam int M_FAIL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       st;
    logic       start;
    logic       temp_ok;
    logic [3:0] num;
    logic       temp;
    logic       busy;
    logic       done;
    logic       fail;

    hatch_seq_ctrl #(
        .STAGE_TICKS (ST),
        .LAST_FRAME  (LF),
        .FAIL_FRAME  (FF),
        .COLD_LIMIT  (CL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .st      (st),
        .start   (start),
        .temp_ok (temp_ok),
        .num     (num),
        .temp    (temp),
        .busy    (busy),
        .done    (done),
        .fail    (fail)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] num;
        logic       temp;
        logic       busy;
        logic       done;
        logic       fail;
    } obs_t;

    typedef struct {
        logic s;
        logic go;
        logic ok;
        obs_t want;
    } vec_t;

    obs_t exp_q[$];
    vec_t tv[16];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   m_state, m_num, m_stage, m_cold;

    function automatic obs_t mk(int n, bit t, bit b, bit d, bit f);
        obs_t o;
        o.num  = 4'(n);
        o.temp = t;
        o.busy = b;
        o.done = d;
        o.fail = f;
        return o;
    endfunction

    function automatic obs_t obs();
        return {num, temp, busy, done, fail};
    endfunction

    function automatic obs_t model_obs();
        return mk(m_num, (m_state == M_COLD) || (m_state == M_FAIL),
                  (m_state == M_RUN) || (m_state == M_COLD),
                  m_state == M_DONE, m_state == M_FAIL);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_num   = 0;
        m_stage = 0;
        m_cold  = 0;
    endtask

    task automatic model_step(input logic s, input logic go, input logic ok);
        if (!s) begin
            model_reset();
        end else begin
            case (m_state)
                M_IDLE, M_DONE, M_FAIL: begin
                    if (go) begin
                        m_state = M_RUN;
                        m_num   = 0;
                        m_stage = 0;
                        m_cold  = 0;
                    end
                end
                M_RUN, M_COLD: begin
                    if (!ok) begin
                        if (m_state == M_COLD && m_cold == CL - 1) begin
                            m_state = M_FAIL;
                            m_num   = FF;
                            m_cold  = 0;
                        end else begin
                            m_state = M_COLD;
                            m_cold++;
                        end
                    end else begin
                        m_state = M_RUN;
                        m_cold  = 0;
                        if (m_stage == ST - 1) begin
                            m_stage = 0;
                            m_num++;
                            if (m_num == LF) m_state = M_DONE;
                        end else begin
                            m_stage++;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got num=%0d temp=%b busy=%b done=%b fail=%b, want num=%0d temp=%b busy=%b done=%b fail=%b",
                     name, got.num, got.temp, got.busy, got.done, got.fail,
                     want.num, want.temp, want.busy, want.done, want.fail);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic step_check(input string name);
        @(posedge clk);
        #1;
        cyc++;
        check(name, obs(), exp_q.pop_front());
    endtask

    task automatic apply(input logic s, input logic go, input logic ok,
                         input string name);
        st      = s;
        start   = go;
        temp_ok = ok;
        model_step(s, go, ok);
        exp_q.push_back(model_obs());
        step_check(name);
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        st      = v.s;
        start   = v.go;
        temp_ok = v.ok;
        model_step(v.s, v.go, v.ok);
        exp_q.push_back(v.want);
        step_check(name);
    endtask

    task automatic run_to_num(input int target, input string name);
        for (int g = 0; g < 200 && m_num != target; g++) apply(1, 0, 1, name);
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b1, 1'b1, mk(0, 0, 1, 0, 0)};
        tv[1]  = '{1'b1, 1'b0, 1'b1, mk(0, 0, 1, 0, 0)};
        tv[2]  = '{1'b1, 1'b0, 1'b0, mk(0, 1, 1, 0, 0)};
        tv[3]  = '{1'b1, 1'b0, 1'b0, mk(0, 1, 1, 0, 0)};
        tv[4]  = '{1'b1, 1'b0, 1'b0, mk(0, 1, 1, 0, 0)};
        tv[5]  = '{1'b1, 1'b0, 1'b0, mk(0, 1, 1, 0, 0)};
        tv[6]  = '{1'b1, 1'b0, 1'b0, mk(0, 1, 1, 0, 0)};
        tv[7]  = '{1'b1, 1'b0, 1'b0, mk(11, 1, 0, 0, 1)};
        tv[8]  = '{1'b1, 1'b0, 1'b0, mk(11, 1, 0, 0, 1)};
        tv[9]  = '{1'b1, 1'b0, 1'b1, mk(11, 1, 0, 0, 1)};
        tv[10] = '{1'b1, 1'b1, 1'b1, mk(0, 0, 1, 0, 0)};
        tv[11] = '{1'b1, 1'b0, 1'b1, mk(0, 0, 1, 0, 0)};
        tv[12] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0)};
        tv[13] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0)};
        tv[14] = '{1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0)};
        tv[15] = '{1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0)};

        // Async reset before any clock edge.
        rst     = 1'b1;
        st      = 1'b0;
        start   = 1'b0;
        temp_ok = 1'b1;
        model_reset();
        #2;
        check("reset_async", obs(), mk(0, 0, 0, 0, 0));
        #1;
        rst = 1'b0;

        // Warm run from start to DONE.
        apply(1, 0, 1, "idle_hold");
        cyc = 0;
        apply(1, 1, 1, "run_start");
        for (int g = 0; g < 100 && !done; g++) apply(1, 0, 1, "run_warm");
        check_int("latency_warm", cyc, 1 + LF * ST);
        check("done_state", obs(), mk(LF, 0, 0, 1, 0));
        apply(1, 0, 1, "done_hold");

        // Three cold cycles mid-stage 2.
        cyc = 0;
        apply(1, 1, 1, "cold_start");
        run_to_num(2, "cold_pre");
        apply(1, 0, 1, "cold_mid");
        for (int i = 0; i < 3; i++) apply(1, 0, 0, "cold_spell");
        for (int g = 0; g < 100 && !done; g++) apply(1, 0, 1, "cold_post");
        check_int("latency_cold", cyc, 1 + LF * ST + 3);

        // Fail, restart, st clear, table-driven.
        for (int i = 0; i < 16; i++) apply_vec(tv[i], $sformatf("vec%0d", i));

        // st dropped at num=5; start ignored while st=0.
        apply(1, 1, 1, "st_start");
        run_to_num(5, "st_run");
        check_int("st_num5", int'(num), 5);
        apply(0, 0, 1, "st_drop");
        apply(0, 1, 1, "st_low_start");
        apply(1, 0, 1, "st_back");

        // start during RUN at num=3 has no effect.
        cyc = 0;
        apply(1, 1, 1, "rs_start");
        run_to_num(3, "rs_run");
        apply(1, 0, 1, "rs_mid");
        apply(1, 1, 1, "rs_restart_ignored");
        for (int g = 0; g < 40 && num != 4'd4; g++) apply(1, 0, 1, "rs_post");
        check_int("rs_num4_cycle", cyc, 1 + 4 * ST);

        // Async reset mid-run, between edges.
        apply(1, 0, 1, "pre_rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_midrun", obs(), mk(0, 0, 0, 0, 0));
        rst = 1'b0;
        model_reset();
        apply(1, 0, 1, "post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
